fetch_sequencer: RTL and testbench

- Synchronous control sequencer for the instruction-fetch datapath: PC counter, memory, AR/IR/I registers and the three-source bus.
- Downstream registers load on rising edges of their strobes. This block therefore issues each strobe as an isolated one-cycle registered pulse, in a fixed order.
- Runs fetch, decode and optional indirect-address phases, then hands off to the execution unit with a start/done handshake.

---
 rtl/fetch_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : Fetch/decode/indirect control sequencer issuing isolated
//             one-cycle registered strobes, with exec start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int EXEC_TIMEOUT = 64,
    parameter int RET_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [15:0]      ir_in,
    input  logic             i_in,
    input  logic             exec_done,
    output logic             bus_x2,
    output logic             bus_x5,
    output logic             bus_x7,
    output logic             mem_read,
    output logic             pc_incr,
    output logic             ld_ar,
    output logic             ld_ir,
    output logic             ld_i,
    output logic             exec_start,
    output logic [2:0]       opcode,
    output logic             indirect,
    output logic             exec_fault,
    output logic             busy,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_F2   = 4'd3,
        ST_F3   = 4'd4,
        ST_F4   = 4'd5,
        ST_D0   = 4'd6,
        ST_D1   = 4'd7,
        ST_I0   = 4'd8,
        ST_I1   = 4'd9,
        ST_I2   = 4'd10,
        ST_EX   = 4'd11
    } state_t;

    localparam int            c_TW      = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
    localparam logic          c_TO_EN   = (EXEC_TIMEOUT > 0);
    localparam logic [c_TW-1:0] c_TO_LAST = (EXEC_TIMEOUT > 0) ? c_TW'(EXEC_TIMEOUT - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    logic             w_done_ok;
    logic             w_timeout;
    logic [c_TW-1:0]  r_ex_cnt;

    logic w_bus_x2, w_bus_x5, w_bus_x7, w_mem_read, w_pc_incr;
    logic w_ld_ar, w_ld_ir, w_ld_i, w_exec_start;

    logic r_bus_x2, r_bus_x5, r_bus_x7, r_mem_read, r_pc_incr;
    logic r_ld_ar, r_ld_ir, r_ld_i, r_exec_start;
    logic [2:0]       r_opcode;
    logic             r_indirect;
    logic             r_exec_fault;
    logic             r_busy;
    logic [RET_W-1:0] r_retired;

    // Only the opcode field takes part in decode.
    logic w_unused_ir;
    assign w_unused_ir = ^{ir_in[15], ir_in[11:0]};

    // Next-state logic. r_exec_start marks the EX entry cycle, where
    // exec_done is not yet accepted.
    always_comb begin
        w_next    = r_state;
        w_done_ok = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: if (run && !r_exec_fault) w_next = ST_F0;
            ST_F0:   w_next = ST_F1;
            ST_F1:   w_next = ST_F2;
            ST_F2:   w_next = ST_F3;
            ST_F3:   w_next = ST_F4;
            ST_F4:   w_next = ST_D0;
            ST_D0:   w_next = ST_D1;
            ST_D1:   w_next = r_indirect ? ST_I0 : ST_EX;
            ST_I0:   w_next = ST_I1;
            ST_I1:   w_next = ST_I2;
            ST_I2:   w_next = ST_EX;
            ST_EX: begin
                if (exec_done && !r_exec_start) begin
                    w_done_ok = 1'b1;
                    w_next    = run ? ST_F0 : ST_IDLE;
                end else if (c_TO_EN && (r_ex_cnt == c_TO_LAST)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered so that the
    // registered copies line up with the state they belong to.
    always_comb begin
        w_bus_x2     = 1'b0;
        w_bus_x5     = 1'b0;
        w_bus_x7     = 1'b0;
        w_mem_read   = 1'b0;
        w_pc_incr    = 1'b0;
        w_ld_ar      = 1'b0;
        w_ld_ir      = 1'b0;
        w_ld_i       = 1'b0;
        w_exec_start = 1'b0;
        case (w_next)
            ST_F0:               w_bus_x2 = 1'b1;
            ST_F1, ST_D1, ST_I2: w_ld_ar  = 1'b1;
            ST_F2: begin
                w_mem_read = 1'b1;
                w_pc_incr  = 1'b1;
            end
            ST_F3, ST_I1:        w_bus_x7 = 1'b1;
            ST_F4: begin
                w_ld_ir = 1'b1;
                w_ld_i  = 1'b1;
            end
            ST_D0:               w_bus_x5   = 1'b1;
            ST_I0:               w_mem_read = 1'b1;
            ST_EX:               w_exec_start = (r_state != ST_EX);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ex_cnt     <= '0;
            r_bus_x2     <= 1'b0;
            r_bus_x5     <= 1'b0;
            r_bus_x7     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_pc_incr    <= 1'b0;
            r_ld_ar      <= 1'b0;
            r_ld_ir      <= 1'b0;
            r_ld_i       <= 1'b0;
            r_exec_start <= 1'b0;
            r_opcode     <= 3'b000;
            r_indirect   <= 1'b0;
            r_exec_fault <= 1'b0;
            r_busy       <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_state      <= w_next;
            r_bus_x2     <= w_bus_x2;
            r_bus_x5     <= w_bus_x5;
            r_bus_x7     <= w_bus_x7;
            r_mem_read   <= w_mem_read;
            r_pc_incr    <= w_pc_incr;
            r_ld_ar      <= w_ld_ar;
            r_ld_ir      <= w_ld_ir;
            r_ld_i       <= w_ld_i;
            r_exec_start <= w_exec_start;
            r_busy       <= (w_next != ST_IDLE);

            if (r_state == ST_D0) begin
                r_opcode   <= ir_in[14:12];
                r_indirect <= i_in && (ir_in[14:12] != 3'b111);
            end

            if (w_done_ok) begin
                r_retired <= r_retired + RET_W'(1);
            end
            if (w_timeout) begin
                r_exec_fault <= 1'b1;
            end

            // Counts cycles spent in EX; zero on the entry cycle.
            if (r_state != ST_EX) begin
                r_ex_cnt <= '0;
            end else if (r_ex_cnt != c_TO_LAST) begin
                r_ex_cnt <= r_ex_cnt + c_TW'(1);
            end
        end
    end

    assign bus_x2     = r_bus_x2;
    assign bus_x5     = r_bus_x5;
    assign bus_x7     = r_bus_x7;
    assign mem_read   = r_mem_read;
    assign pc_incr    = r_pc_incr;
    assign ld_ar      = r_ld_ar;
    assign ld_ir      = r_ld_ir;
    assign ld_i       = r_ld_i;
    assign exec_start = r_exec_start;
    assign opcode     = r_opcode;
    assign indirect   = r_indirect;
    assign exec_fault = r_exec_fault;
    assign busy       = r_busy;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Brief    : Self-checking bench for fetch_sequencer against a strobe-schedule
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_RET_W   = 4;

    // Strobe vector bit order: x2 x5 x7 mem pc ar ir i start
    localparam logic [8:0] S_X2  = 9'b100000000;
    localparam logic [8:0] S_X5  = 9'b010000000;
    localparam logic [8:0] S_X7  = 9'b001000000;
    localparam logic [8:0] S_MEM = 9'b000100000;
    localparam logic [8:0] S_PC  = 9'b000010000;
    localparam logic [8:0] S_AR  = 9'b000001000;
    localparam logic [8:0] S_IR  = 9'b000000100;
    localparam logic [8:0] S_I   = 9'b000000010;
    localparam logic [8:0] S_ES  = 9'b000000001;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                run = 1'b0;
    logic [15:0]         ir_in = 16'h0000;
    logic                i_in = 1'b0;
    logic                exec_done = 1'b0;
    logic                bus_x2, bus_x5, bus_x7, mem_read, pc_incr;
    logic                ld_ar, ld_ir, ld_i, exec_start;
    logic [2:0]          opcode;
    logic                indirect, exec_fault, busy;
    logic [TB_RET_W-1:0] retired;
    logic [8:0]          vec;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    fetch_sequencer #(
        .EXEC_TIMEOUT (TB_TIMEOUT),
        .RET_W        (TB_RET_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ir_in      (ir_in),
        .i_in       (i_in),
        .exec_done  (exec_done),
        .bus_x2     (bus_x2),
        .bus_x5     (bus_x5),
        .bus_x7     (bus_x7),
        .mem_read   (mem_read),
        .pc_incr    (pc_incr),
        .ld_ar      (ld_ar),
        .ld_ir      (ld_ir),
        .ld_i       (ld_i),
        .exec_start (exec_start),
        .opcode     (opcode),
        .indirect   (indirect),
        .exec_fault (exec_fault),
        .busy       (busy),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    assign vec = {bus_x2, bus_x5, bus_x7, mem_read, pc_incr, ld_ar, ld_ir, ld_i, exec_start};

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        exec_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_ret = 0;
    endtask

    // Runs one instruction starting at a point where the next edge enters F0.
    task automatic do_instr(input string nm, input logic [15:0] ir, input logic iv,
                            input int dly, input logic run_end, input logic noise,
                            input logic done_at_entry);
        logic [8:0] exp_q[$];
        logic       ind;
        int         last;
        ind   = iv && (ir[14:12] != 3'b111);
        exp_q = {S_X2, S_AR, S_MEM | S_PC, S_X7, S_IR | S_I, S_X5, S_AR};
        if (ind) begin
            exp_q.push_back(S_MEM);
            exp_q.push_back(S_X7);
            exp_q.push_back(S_AR);
        end
        exp_q.push_back(S_ES);
        last  = exp_q.size() - 1;
        ir_in = ir;
        i_in  = iv;
        run   = 1'b1;
        foreach (exp_q[k]) begin
            @(posedge clk);
            #1;
            exec_done = noise ? 1'($urandom) : 1'b0;
            run       = noise ? 1'($urandom) : 1'b1;
            if (noise && k >= 6) begin
                ir_in = 16'($urandom);
                i_in  = 1'($urandom);
            end
            if (k == last) exec_done = done_at_entry;
            n_checks++;
            if (vec !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s strobes cyc=%0d got=%b exp=%b", nm, k, vec, exp_q[k]);
            end
            if (k == 0) begin
                n_checks++;
                if (busy !== 1'b1 || retired !== TB_RET_W'(exp_ret)) begin
                    n_fail++;
                    $display("FAIL %s start busy=%b retired=%0d exp_retired=%0d", nm, busy, retired, exp_ret);
                end
            end
        end
        n_checks++;
        if (opcode !== ir[14:12] || indirect !== ind) begin
            n_fail++;
            $display("FAIL %s decode opcode=%b ind=%b exp_opcode=%b exp_ind=%b", nm, opcode, indirect, ir[14:12], ind);
        end
        for (int d = 1; d <= dly; d++) begin
            @(posedge clk);
            #1;
            exec_done = 1'b0;
            n_checks++;
            if (vec !== 9'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s exec_wait d=%0d strobes=%b busy=%b exp=0/1", nm, d, vec, busy);
            end
            if (d == dly) begin
                exec_done = 1'b1;
                run       = run_end;
            end else if (noise) begin
                run = 1'($urandom);
            end
        end
        exp_ret = (exp_ret + 1) % (1 << TB_RET_W);
        if (!run_end) begin
            @(posedge clk);
            #1;
            exec_done = 1'b0;
            n_checks++;
            if (vec !== 9'b0 || busy !== 1'b0 || retired !== TB_RET_W'(exp_ret)) begin
                n_fail++;
                $display("FAIL %s to_idle strobes=%b busy=%b retired=%0d exp_retired=%0d", nm, vec, busy, retired, exp_ret);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (vec !== 9'b0 || busy !== 1'b0 || exec_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_asserted strobes=%b busy=%b fault=%b exp=0", vec, busy, exec_fault);
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (vec !== 9'b0 || busy !== 1'b0 || opcode !== 3'b0 || indirect !== 1'b0 ||
                exec_fault !== 1'b0 || retired !== '0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d strobes=%b busy=%b op=%b ind=%b fault=%b ret=%0d exp=all0",
                         c, vec, busy, opcode, indirect, exec_fault, retired);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_direct();
        do_instr("direct", 16'h2005, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_indirect();
        do_instr("indirect", 16'hA005, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_op7();
        do_instr("op7", 16'hF800, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_instr("b2b_first", 16'h2005, 1'b0, 3, 1'b1, 1'b0, 1'b1);
        do_instr("b2b_second", 16'hA123, 1'b1, 3, 1'b1, 1'b0, 1'b1);
        do_instr("b2b_third", 16'h7FFF, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [15:0] ir;
            logic        iv;
            ir = 16'($urandom);
            iv = 1'($urandom);
            if (n % 7 == 3) begin
                ir[14:12] = 3'b111;
                iv        = 1'b1;
            end
            do_instr("random", ir, iv, int'($urandom_range(1, 6)),
                     (n == 29) ? 1'b0 : 1'($urandom), 1'b1, 1'($urandom));
        end
    endtask

    task automatic test_timeout();
        logic [8:0] exp_q[$];
        exp_q = {S_X2, S_AR, S_MEM | S_PC, S_X7, S_IR | S_I, S_X5, S_AR, S_ES};
        ir_in = 16'h2005;
        i_in  = 1'b0;
        run   = 1'b1;
        foreach (exp_q[k]) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (vec !== exp_q[k]) begin
                n_fail++;
                $display("FAIL timeout_fetch cyc=%0d got=%b exp=%b", k, vec, exp_q[k]);
            end
        end
        for (int d = 1; d < TB_TIMEOUT; d++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b1 || exec_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early d=%0d busy=%b fault=%b exp=1/0", d, busy, exec_fault);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (exec_fault !== 1'b1 || busy !== 1'b0 || vec !== 9'b0 || retired !== TB_RET_W'(exp_ret)) begin
            n_fail++;
            $display("FAIL timeout_fault fault=%b busy=%b strobes=%b ret=%0d exp=1/0/0/%0d",
                     exec_fault, busy, vec, retired, exp_ret);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b0 || vec !== 9'b0 || exec_fault !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_locked c=%0d busy=%b strobes=%b fault=%b exp=0/0/1", c, busy, vec, exec_fault);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        n_checks++;
        if (exec_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear fault=%b exp=0", exec_fault);
        end
        do_instr("pre_reset", 16'h3001, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        ir_in = 16'h2005;
        i_in  = 1'b0;
        run   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (vec !== S_X7) begin
            n_fail++;
            $display("FAIL midreset_f3 got=%b exp=%b", vec, S_X7);
        end
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        n_checks++;
        if (vec !== 9'b0 || busy !== 1'b0 || retired !== '0 || opcode !== 3'b0 || indirect !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async strobes=%b busy=%b ret=%0d op=%b ind=%b exp=all0",
                     vec, busy, retired, opcode, indirect);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (vec !== 9'b0 || busy !== 1'b0 || retired !== '0) begin
                n_fail++;
                $display("FAIL midreset_after c=%0d strobes=%b busy=%b ret=%0d exp=0", c, vec, busy, retired);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_indirect();
        test_op7();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_midfetch();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
